// File: rtl/mult_array_pipe_hs_if.sv
// Valid/ready bundle for the pipelined array multiplier: operand/tag input
// channel and product/tag output channel.
interface mult_array_pipe_hs_if #(
   parameter int WIDTH = 8,
   parameter int TAG_W = 4
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               sgn;
   logic [TAG_W-1:0]   in_tag;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] y;
   logic [TAG_W-1:0]   out_tag;

   modport master (
      output in_valid, a, b, sgn, in_tag, out_ready,
      input  in_ready, out_valid, y, out_tag
   );

   modport slave (
      input  in_valid, a, b, sgn, in_tag, out_ready,
      output in_ready, out_valid, y, out_tag
   );
endinterface

// File: rtl/mult_array_pipe_hs.sv
// Pipelined array multiplier with valid/ready flow control, per-op signed or
// unsigned mode (Baugh-Wooley rows) and a tag that travels with each op.
module mult_array_pipe_hs #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 4,
   parameter int TAG_W  = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   mult_array_pipe_hs_if.slave bus
);
   localparam int R  = (WIDTH + STAGES - 1) / STAGES;
   localparam int PW = 2 * WIDTH;
   // Baugh-Wooley constant: +2^WIDTH +2^(2*WIDTH-1), folded into stage 0.
   localparam logic [PW-1:0] BW_CORR = (PW'(1) << (PW - 1)) | (PW'(1) << WIDTH);

   logic advance_s;

   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      localparam int LO = g * R;
      localparam int HI = (((g + 1) * R) < WIDTH) ? ((g + 1) * R) : WIDTH;

      logic [WIDTH-1:0] a_i_s;
      logic [WIDTH-1:0] b_i_s;
      logic             sgn_i_s;
      logic             vld_i_s;
      logic [TAG_W-1:0] tag_i_s;
      logic [PW-1:0]    sum_i_s;
      logic [PW-1:0]    sum_nxt_s;
      logic [PW-1:0]    row_s;
      logic             vld_r;
      logic [TAG_W-1:0] tag_r;
      logic [PW-1:0]    sum_r;

      if (g == 0) begin : g_head
         assign a_i_s   = bus.a;
         assign b_i_s   = bus.b;
         assign sgn_i_s = bus.sgn;
         assign vld_i_s = bus.in_valid;
         assign tag_i_s = bus.in_tag;
         assign sum_i_s = bus.sgn ? BW_CORR : '0;
      end else begin : g_body
         assign a_i_s   = g_stage[g-1].g_ops.a_r;
         assign b_i_s   = g_stage[g-1].g_ops.b_r;
         assign sgn_i_s = g_stage[g-1].g_ops.sgn_r;
         assign vld_i_s = g_stage[g-1].vld_r;
         assign tag_i_s = g_stage[g-1].tag_r;
         assign sum_i_s = g_stage[g-1].sum_r;
      end

      // Add this stage's rows; in signed mode the cross terms with exactly one sign bit are inverted.
      always_comb begin
         sum_nxt_s = sum_i_s;
         row_s     = '0;
         for (int j = LO; j < HI; j++) begin
            row_s = '0;
            for (int i = 0; i < WIDTH; i++) begin
               row_s[i + j] = (a_i_s[i] & b_i_s[j]) ^
                              (sgn_i_s & ((i == WIDTH - 1) != (j == WIDTH - 1)));
            end
            sum_nxt_s = sum_nxt_s + row_s;
         end
      end

      // Stage register: valid, tag and partial sum move only on a global advance.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_r <= 1'b0;
            tag_r <= '0;
            sum_r <= '0;
         end else if (advance_s) begin
            vld_r <= vld_i_s;
            tag_r <= tag_i_s;
            sum_r <= sum_nxt_s;
         end
      end

      if (g < STAGES - 1) begin : g_ops
         logic [WIDTH-1:0] a_r;
         logic [WIDTH-1:0] b_r;
         logic             sgn_r;

         // Operands are only needed by later stages, so the last stage drops them.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_r   <= '0;
               b_r   <= '0;
               sgn_r <= 1'b0;
            end else if (advance_s) begin
               a_r   <= a_i_s;
               b_r   <= b_i_s;
               sgn_r <= sgn_i_s;
            end
         end
      end
   end

   assign advance_s     = !g_stage[STAGES-1].vld_r || bus.out_ready;
   assign bus.in_ready  = advance_s;
   assign bus.out_valid = g_stage[STAGES-1].vld_r;
   assign bus.y         = g_stage[STAGES-1].sum_r;
   assign bus.out_tag   = g_stage[STAGES-1].tag_r;
endmodule

// File: tb/tb_mult_array_pipe_hs.sv
// Directed bench for mult_array_pipe_hs with a queue scoreboard, plus
// parameter-sweep instances that self-drive once the directed part is done.
module tb_mult_array_pipe_hs;
   localparam int W = 8;
   localparam int S = 4;
   localparam int T = 8;

   logic clk      = 1'b0;
   logic rst_n    = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   n_out    = 0;
   bit   chk_lat  = 1'b0;
   bit   sweep_go = 1'b0;

   logic [2*W-1:0] qy[$];
   logic [T-1:0]   qt[$];
   int             qa[$];
   logic [2*W-1:0] ty;
   logic [T-1:0]   tt;
   int             ta;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mult_array_pipe_hs_if #(.WIDTH(W), .TAG_W(T)) bus ();
   mult_array_pipe_hs #(.WIDTH(W), .STAGES(S), .TAG_W(T)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp_v);
      end
   endtask

   function automatic logic [2*W-1:0] ref8(input logic [W-1:0] x, input logic [W-1:0] z, input logic s);
      logic signed [2*W-1:0] xe;
      logic signed [2*W-1:0] ze;
      xe = s ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
      ze = s ? {{W{z[W-1]}}, z} : {{W{1'b0}}, z};
      return xe * ze;
   endfunction

   // Transfers are decided on the falling edge, one half-cycle before the edge that performs them.
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qy.delete();
         qt.delete();
         qa.delete();
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            chk("out_expected", 32'(qy.size() != 0), 32'd1);
            if (qy.size() != 0) begin
               ty = qy.pop_front();
               tt = qt.pop_front();
               ta = qa.pop_front();
               chk("y", 32'(bus.y), 32'(ty));
               chk("out_tag", 32'(bus.out_tag), 32'(tt));
               if (chk_lat) chk("latency", 32'(cyc - ta), 32'(S - 1));
               n_out++;
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            qy.push_back(ref8(bus.a, bus.b, bus.sgn));
            qt.push_back(bus.in_tag);
            qa.push_back(cyc + 1);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] x, input logic [W-1:0] z, input logic s, input logic [T-1:0] t);
      bit ok;
      ok = 1'b0;
      bus.a        = x;
      bus.b        = z;
      bus.sgn      = s;
      bus.in_tag   = t;
      bus.in_valid = 1'b1;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge clk);
         ok = bus.in_ready;
         step();
      end
      chk("send_accepted", 32'(ok), 32'd1);
   endtask

   task automatic drain(input string name);
      for (int k = 0; k < 100 && qy.size() != 0; k++) step();
      chk(name, 32'(qy.size()), 32'd0);
   endtask

   for (genvar k = 0; k < 3; k++) begin : g_sw
      localparam int SW   = (k == 0) ? 4 : ((k == 1) ? 16 : 8);
      localparam int SS   = (k == 0) ? 1 : ((k == 1) ? 16 : 3);
      localparam int NOPS = (k == 0) ? 512 : 1000;

      bit             done_f = 1'b0;
      logic [2*SW-1:0] sqy[$];
      logic [3:0]      sqt[$];
      int              sqa[$];
      logic [2*SW-1:0] sy_t;
      logic [3:0]      st_t;
      int              sa_t;

      mult_array_pipe_hs_if #(.WIDTH(SW), .TAG_W(4)) sbus ();
      mult_array_pipe_hs #(.WIDTH(SW), .STAGES(SS), .TAG_W(4)) u_dut (
         .clk  (clk),
         .rst_n(rst_n),
         .bus  (sbus)
      );

      function automatic logic [2*SW-1:0] refm(input logic [SW-1:0] x, input logic [SW-1:0] z, input logic s);
         logic signed [2*SW-1:0] xe;
         logic signed [2*SW-1:0] ze;
         xe = s ? {{SW{x[SW-1]}}, x} : {{SW{1'b0}}, x};
         ze = s ? {{SW{z[SW-1]}}, z} : {{SW{1'b0}}, z};
         return xe * ze;
      endfunction

      always @(negedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sqy.delete();
            sqt.delete();
            sqa.delete();
         end else if (sweep_go) begin
            if (sbus.out_valid && sbus.out_ready) begin
               chk("sw_out_expected", 32'(sqy.size() != 0), 32'd1);
               if (sqy.size() != 0) begin
                  sy_t = sqy.pop_front();
                  st_t = sqt.pop_front();
                  sa_t = sqa.pop_front();
                  chk("sw_y", 32'(sbus.y), 32'(sy_t));
                  chk("sw_tag", 32'(sbus.out_tag), 32'(st_t));
                  chk("sw_latency", 32'(cyc - sa_t), 32'(SS - 1));
               end
            end
            if (sbus.in_valid && sbus.in_ready) begin
               sqy.push_back(refm(sbus.a, sbus.b, sbus.sgn));
               sqt.push_back(sbus.in_tag);
               sqa.push_back(cyc + 1);
            end
         end
      end

      initial begin
         logic [31:0] r;
         sbus.in_valid  = 1'b0;
         sbus.a         = '0;
         sbus.b         = '0;
         sbus.sgn       = 1'b0;
         sbus.in_tag    = '0;
         sbus.out_ready = 1'b1;
         wait (sweep_go);
         step();
         // SW=4 walks all 512 {sgn,b,a} combinations; wider ones use random operands.
         for (int n = 0; n < NOPS; n++) begin
            r = (SW == 4) ? 32'(n) : $urandom();
            sbus.a        = r[SW-1:0];
            sbus.b        = r[2*SW-1:SW];
            sbus.sgn      = (SW == 4) ? r[8] : 1'($urandom_range(0, 1));
            sbus.in_tag   = 4'(n);
            sbus.in_valid = 1'b1;
            @(negedge clk);
            chk("sw_in_ready", 32'(sbus.in_ready), 32'd1);
            step();
         end
         sbus.in_valid = 1'b0;
         for (int j = 0; j < 64 && sqy.size() != 0; j++) step();
         chk("sw_drain", 32'(sqy.size()), 32'd0);
         done_f = 1'b1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] xs;
      int          base;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.sgn       = 1'b0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b1;

      #3;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_y", 32'(bus.y), 32'd0);
      chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      #10 rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
      end
      step();

      // unsigned back-to-back stream, including 0xFF*0xFF
      chk_lat = 1'b1;
      base    = n_out;
      xs      = 32'h1234_5678;
      for (int n = 0; n < 20; n++) begin
         xs ^= xs << 13;
         xs ^= xs >> 17;
         xs ^= xs << 5;
         if (n == 7) send(8'hFF, 8'hFF, 1'b0, T'(n));
         else        send(xs[7:0], xs[15:8], 1'b0, T'(n));
      end
      bus.in_valid = 1'b0;
      drain("t2_drain");
      chk("t2_count", 32'(n_out - base), 32'd20);

      // signed corners interleaved with unsigned ops
      base = n_out;
      send(8'h80, 8'h80, 1'b1, 8'hC8);
      send(8'h80, 8'h80, 1'b0, 8'hC9);
      send(8'h80, 8'h7F, 1'b1, 8'hCA);
      send(8'hFF, 8'h01, 1'b1, 8'hCB);
      send(8'hFF, 8'h01, 1'b0, 8'hCC);
      bus.in_valid = 1'b0;
      drain("t3_drain");
      chk("t3_count", 32'(n_out - base), 32'd5);

      // backpressure mid-stream
      chk_lat = 1'b0;
      base    = n_out;
      fork
         begin
            logic [2*W-1:0] hy;
            logic [T-1:0]   ht;
            repeat (8) step();
            bus.out_ready = 1'b0;
            @(negedge clk);
            hy = bus.y;
            ht = bus.out_tag;
            chk("t4_in_ready", 32'(bus.in_ready), 32'd0);
            chk("t4_out_valid", 32'(bus.out_valid), 32'd1);
            repeat (2) begin
               step();
               @(negedge clk);
               chk("t4_in_ready", 32'(bus.in_ready), 32'd0);
               chk("t4_y_hold", 32'(bus.y), 32'(hy));
               chk("t4_tag_hold", 32'(bus.out_tag), 32'(ht));
            end
            step();
            bus.out_ready = 1'b1;
         end
      join_none
      for (int n = 0; n < 20; n++) begin
         xs ^= xs << 13;
         xs ^= xs >> 17;
         xs ^= xs << 5;
         send(xs[7:0], xs[15:8], xs[16], T'(100 + n));
      end
      bus.in_valid = 1'b0;
      drain("t4_drain");
      chk("t4_count", 32'(n_out - base), 32'd20);

      // asynchronous reset with three ops in flight and the output stalled
      bus.out_ready = 1'b0;
      send(8'h11, 8'h22, 1'b0, 8'hA0);
      send(8'h33, 8'h44, 1'b1, 8'hA1);
      send(8'h55, 8'h66, 1'b0, 8'hA2);
      bus.in_valid = 1'b0;
      step();
      chk("t5_pre_valid", 32'(bus.out_valid), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("t5_async_valid", 32'(bus.out_valid), 32'd0);
      chk("t5_async_y", 32'(bus.y), 32'd0);
      #1 rst_n = 1'b1;
      bus.out_ready = 1'b1;
      base = n_out;
      repeat (8) begin
         @(negedge clk);
         chk("t5_no_stale", 32'(bus.out_valid), 32'd0);
      end
      step();
      chk_lat = 1'b1;
      send(8'h12, 8'h34, 1'b0, 8'h55);
      bus.in_valid = 1'b0;
      drain("t5_drain");
      chk("t5_count", 32'(n_out - base), 32'd1);

      // parameter sweep instances
      sweep_go = 1'b1;
      for (int i = 0; i < 3000 && !(g_sw[0].done_f && g_sw[1].done_f && g_sw[2].done_f); i++) step();
      chk("sweep_done", 32'({g_sw[0].done_f, g_sw[1].done_f, g_sw[2].done_f}), 32'd7);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
